writeback_arbiter: RTL

//  Merges results from several execution sources (ALU, load unit, FPU, ...) onto the single

---
 rtl/writeback_arbiter_pkg.sv | 22 ++
 rtl/writeback_arbiter_prio_pick.sv | 32 +++
 rtl/writeback_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package writeback_arbiter_pkg;

   // Default geometry of one integer register file write port
   localparam int WB_ADDR_W = 6;
   localparam int WB_DATA_W = 32;

   // One pending register-file write
   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;

   // Architectural zero register: writes to it are accepted and dropped
   localparam int REG_ZERO = 0;

   // Conventional source slots (index 0 has the highest base priority)
   localparam int WB_SRC_ALU  = 0;
   localparam int WB_SRC_LOAD = 1;
   localparam int WB_SRC_FPU  = 2;

endpackage

// File: rtl/writeback_arbiter_prio_pick.sv
// Combinational grant picker: starved sources first, then fixed priority.
module wb_prio_pick #(
   parameter int NSRC  = 3,
   parameter int IDX_W = 2
) (
   input  logic [NSRC-1:0]  i_valid,
   input  logic [NSRC-1:0]  i_starved,
   output logic [NSRC-1:0]  o_grant,
   output logic [IDX_W-1:0] o_idx
);

   logic [NSRC-1:0] w_stv;
   logic [NSRC-1:0] w_cand;

   // A starved request only counts while it is still presented
   assign w_stv  = i_valid & i_starved;
   assign w_cand = (|w_stv) ? w_stv : i_valid;

   // Scan high to low so the lowest-index candidate is the last one written
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (w_cand[i]) begin
            o_grant    = '0;
            o_grant[i] = 1'b1;
            o_idx      = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges execution-unit results onto one register-file write port.
// Fixed priority with a per-source starvation override; 1-cycle latency.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int NSRC         = 3,
   parameter int ADDR_W       = 6,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   localparam int IDX_W       = (NSRC > 1) ? $clog2(NSRC) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NSRC-1:0]              src_valid,
   input  logic [NSRC-1:0][ADDR_W-1:0]  src_addr,
   input  logic [NSRC-1:0][DATA_W-1:0]  src_data,
   output logic [NSRC-1:0]              src_ready,
   output logic                         wb_en,
   output logic [ADDR_W-1:0]            wb_addr,
   output logic [DATA_W-1:0]            wb_data,
   output logic [IDX_W-1:0]             wb_src,
   output logic [NSRC-1:0]              starved
);

   localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

   logic [NSRC-1:0][3:0]  r_cnt;
   logic                  r_en;
   logic [ADDR_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_data;
   logic [IDX_W-1:0]      r_src;

   logic [NSRC-1:0]       w_starved;
   logic [NSRC-1:0]       w_pick;
   logic [NSRC-1:0]       w_grant;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_any;
   logic [ADDR_W-1:0]     w_sel_addr;
   logic [DATA_W-1:0]     w_sel_data;

   // Starved flags come straight from the saturated counters
   always_comb begin
      w_starved = '0;
      for (int i = 0; i < NSRC; i++) w_starved[i] = (r_cnt[i] == LIM);
   end

   wb_prio_pick #(
      .NSRC  (NSRC),
      .IDX_W (IDX_W)
   ) u_pick (
      .i_valid   (src_valid),
      .i_starved (w_starved),
      .o_grant   (w_pick),
      .o_idx     (w_idx)
   );

   // Reset gates the handshake so nothing transfers while it is held
   assign w_grant    = rst ? '0 : w_pick;
   assign w_any      = |w_grant;
   assign w_sel_addr = src_addr[w_idx];
   assign w_sel_data = src_data[w_idx];

   // Starve counters: count lost cycles, clear on grant or idle, saturate
   always_ff @(posedge clk) begin
      for (int i = 0; i < NSRC; i++) begin
         if (rst)
            r_cnt[i] <= '0;
         else if (src_valid[i] && !w_grant[i])
            r_cnt[i] <= (r_cnt[i] == LIM) ? LIM : r_cnt[i] + 4'd1;
         else
            r_cnt[i] <= '0;
      end
   end

   // Output register; zero-register writes update payload but not enable
   always_ff @(posedge clk) begin
      if (rst) begin
         r_en   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
         r_src  <= '0;
      end else if (w_any) begin
         r_en   <= (w_sel_addr != ADDR_W'(REG_ZERO));
         r_addr <= w_sel_addr;
         r_data <= w_sel_data;
         r_src  <= w_idx;
      end else begin
         r_en   <= 1'b0;
      end
   end

   assign src_ready = w_grant;
   assign starved   = w_starved;
   assign wb_en     = r_en;
   assign wb_addr   = r_addr;
   assign wb_data   = r_data;
   assign wb_src    = r_src;

endmodule
